mem_qspi_read_ctrl: RTL and testbench
=====================================

MEM_QSPI_READ_CTRL -- requirements
Module: mem_qspi_read_ctrl

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h8000_0000, byte address of flash byte 0 in the core memory map; only bits [31:24] are compared.
REQ-002 SHALL have parameter READ_CMD, default 8'h6B, flash quad-output fast-read opcode.
REQ-003 SHALL have parameter DUMMY_CYCLES, default 8, SCK periods between the address and data phases.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 mem_req_i  input  1  core memory request; held high until granted.
REQ-007 mem_gnt_o  output  1  request accepted in any cycle with mem_req_i & mem_gnt_o.
REQ-008 mem_we_i  input  1  write request; unsupported.
REQ-009 mem_addr_i  input  32  byte address; bits [1:0] ignored.
REQ-010 mem_rvalid_o  output  1  one-cycle response strobe.
REQ-011 mem_err_o  output  1  error flag; valid only with mem_rvalid_o.
REQ-012 mem_rdata_o  output  32  read data; valid only with mem_rvalid_o.
REQ-013 qspi_io_i  input  4  flash IO sampled values.
REQ-014 qspi_io_o  output  4  flash IO drive values.
REQ-015 qspi_io_t  output  4  per-bit tristate; 1 = released (input).
REQ-016 qspi_ck_o  output  1  flash SCK.
REQ-017 qspi_cs_o  output  1  flash chip select, active low.

Function
REQ-018 SHALL implement states IDLE, CMD, ADDR, DUMMY, DATA, RESP, GUARD.
REQ-019 mem_gnt_o SHALL be 1 only in IDLE.
REQ-020 On acceptance with mem_we_i=1 or mem_addr_i[31:24] != BASE_ADDR[31:24], SHALL go to RESP without flash traffic; RESP then asserts mem_rvalid_o=1, mem_err_o=1, mem_rdata_o=0.
REQ-021 On a valid read acceptance, SHALL latch flash address {mem_addr_i[23:2],2'b00} and enter CMD.
REQ-022 In CMD/ADDR/DUMMY/DATA: qspi_cs_o=0; an internal phase bit toggles every clk, starting at 0 on state entry; qspi_ck_o equals the phase bit.
REQ-023 Shift data SHALL change only in cycles with phase=0; each SCK period is 2 clk.
REQ-024 CMD: 8 periods; READ_CMD on qspi_io_o[0], MSB first; qspi_io_t=4'b0010; qspi_io_o[3:2]=2'b11 (HOLD#/WP# inactive).
REQ-025 ADDR: 24 periods; address MSB first on io[0]; same io_t/io_o[3:2] as CMD.
REQ-026 DUMMY: DUMMY_CYCLES periods; qspi_io_t=4'b1111.
REQ-027 DATA: 8 periods; qspi_io_t=4'b1111; qspi_io_i captured at the end of each phase=1 cycle.
REQ-028 Nibble order: high nibble first per byte; first byte received -> mem_rdata_o[7:0], fourth -> [31:24] (little-endian).
REQ-029 After the last DATA phase=1 cycle, SHALL enter RESP: qspi_cs_o=1, qspi_ck_o=0, mem_rvalid_o=1, mem_err_o=0, assembled mem_rdata_o.
REQ-030 RESP lasts exactly 1 clk; valid-read RESP goes to GUARD, error RESP goes to IDLE.
REQ-031 GUARD holds qspi_cs_o=1 for 2 clk, then IDLE (minimum CS-high time).
REQ-032 Valid-read latency with defaults: acceptance at cycle 0, qspi_cs_o low cycles 1..96, mem_rvalid_o at cycle 97, next mem_gnt_o at cycle 100.
REQ-033 Requests arriving outside IDLE SHALL not be accepted; the requester holds mem_req_i, and there is no queueing.
REQ-034 mem_rvalid_o SHALL be exactly one pulse per accepted request.
REQ-035 mem_rdata_o SHALL be 0 whenever mem_rvalid_o=0.
REQ-036 In IDLE and GUARD: qspi_ck_o=0, qspi_cs_o=1, qspi_io_t=4'b1111, qspi_io_o=4'b0000.

Reset
REQ-037 While rst=1 at a clock edge: state=IDLE, phase=0, qspi_cs_o=1, qspi_ck_o=0, qspi_io_t=4'b1111, qspi_io_o=0, mem_rvalid_o=0, mem_err_o=0, mem_rdata_o=0, mem_gnt_o=0.
REQ-038 mem_gnt_o SHALL assert the first cycle after rst deasserts.
REQ-039 Reset mid-transaction SHALL abort it: CS high at the next edge, no mem_rvalid_o ever issued for the aborted request.

Verification
REQ-040 Flash model returns bytes 11,22,33,44 at 0x000100; read of 0x8000_0100 -> serial stream 6B then 000100 on io0, then 8 dummy periods, rvalid at cycle 97, rdata=32'h4433_2211, err=0.
REQ-041 Read with mem_addr_i=0x8000_0103 -> flash address 0x000100, same data as REQ-040.
REQ-042 Write (we=1) to 0x8000_0000 -> rvalid+err at cycle 2, rdata=0, qspi_cs_o never low.
REQ-043 Read of 0x0000_2000 -> err response at cycle 2, no SCK toggles.
REQ-044 Second request held high during a transfer -> no grant until cycle 100, then second transfer starts with CS high for at least 3 clk between transfers.
REQ-045 rst pulsed at cycle 40 of a read -> qspi_cs_o=1 at the next edge, no rvalid, next read completes normally.

Source files
------------

// File: rtl/mem_qspi_read_ctrl_if.sv
// Core memory bus and QSPI pad signals for mem_qspi_read_ctrl.
// slave = the controller; master = core requester plus flash pad side.
interface mem_qspi_read_ctrl_if;
    logic        mem_req_i;
    logic        mem_gnt_o;
    logic        mem_we_i;
    logic [31:0] mem_addr_i;
    logic        mem_rvalid_o;
    logic        mem_err_o;
    logic [31:0] mem_rdata_o;
    logic [3:0]  qspi_io_i;
    logic [3:0]  qspi_io_o;
    logic [3:0]  qspi_io_t;
    logic        qspi_ck_o;
    logic        qspi_cs_o;

    modport slave (
        input  mem_req_i, mem_we_i, mem_addr_i, qspi_io_i,
        output mem_gnt_o, mem_rvalid_o, mem_err_o, mem_rdata_o,
        output qspi_io_o, qspi_io_t, qspi_ck_o, qspi_cs_o
    );

    modport master (
        output mem_req_i, mem_we_i, mem_addr_i, qspi_io_i,
        input  mem_gnt_o, mem_rvalid_o, mem_err_o, mem_rdata_o,
        input  qspi_io_o, qspi_io_t, qspi_ck_o, qspi_cs_o
    );
endinterface

// File: rtl/mem_qspi_read_ctrl.sv
// Memory-mapped read-only QSPI flash controller: one 32-bit quad-output
// fast read per core request; writes and out-of-window reads return an error.
module mem_qspi_read_ctrl #(
    parameter logic [31:0] BASE_ADDR    = 32'h8000_0000,
    parameter logic [7:0]  READ_CMD     = 8'h6B,
    parameter int unsigned DUMMY_CYCLES = 8
) (
    input logic                  clk,
    input logic                  rst,
    mem_qspi_read_ctrl_if.slave  bus
);

    typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DATA, RESP, GUARD} state_e;

    localparam logic [7:0] DUMMY_LAST = (DUMMY_CYCLES == 0) ? 8'd0 : 8'(DUMMY_CYCLES - 1);

    state_e      state_q, state_d;
    logic        phase_q, phase_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] sh_q, sh_d;
    logic [31:0] rx_q, rx_d;
    logic        err_q, err_d;
    logic        wait_q, wait_d;

    logic        gnt_q, gnt_d;
    logic        cs_q, cs_d;
    logic        ck_q, ck_d;
    logic [3:0]  io_t_q, io_t_d;
    logic [3:0]  io_o_q, io_o_d;
    logic        rvalid_q, rvalid_d;
    logic        err_o_q, err_o_d;
    logic [31:0] rdata_q, rdata_d;

    logic active, period_end, act_next, drive_next;
    logic unused_addr_lsbs;

    assign unused_addr_lsbs = ^bus.mem_addr_i[1:0];

    always_comb begin
        state_d = state_q;
        phase_d = 1'b0;
        cnt_d   = cnt_q;
        sh_d    = sh_q;
        rx_d    = rx_q;
        err_d   = err_q;
        wait_d  = 1'b0;

        active     = state_q inside {CMD, ADDR, DUMMY, DATA};
        period_end = active && phase_q;
        if (active) phase_d = ~phase_q;
        if (period_end) cnt_d = cnt_q + 8'd1;

        case (state_q)
            IDLE: begin
                if (bus.mem_req_i && gnt_q) begin
                    if (bus.mem_we_i || (bus.mem_addr_i[31:24] != BASE_ADDR[31:24])) begin
                        state_d = RESP;
                        err_d   = 1'b1;
                        wait_d  = 1'b1;
                    end else begin
                        state_d = CMD;
                        err_d   = 1'b0;
                        cnt_d   = '0;
                        sh_d    = {READ_CMD, bus.mem_addr_i[23:2], 2'b00};
                    end
                end
            end
            CMD: begin
                if (period_end) begin
                    sh_d = {sh_q[30:0], 1'b0};
                    if (cnt_q == 8'd7) begin
                        state_d = ADDR;
                        cnt_d   = '0;
                    end
                end
            end
            ADDR: begin
                if (period_end) begin
                    sh_d = {sh_q[30:0], 1'b0};
                    if (cnt_q == 8'd23) begin
                        state_d = (DUMMY_CYCLES == 0) ? DATA : DUMMY;
                        cnt_d   = '0;
                    end
                end
            end
            DUMMY: begin
                if (period_end && (cnt_q == DUMMY_LAST)) begin
                    state_d = DATA;
                    cnt_d   = '0;
                end
            end
            DATA: begin
                if (period_end) begin
                    rx_d = {rx_q[27:0], bus.qspi_io_i};
                    if (cnt_q == 8'd7) begin
                        state_d = RESP;
                        cnt_d   = '0;
                    end
                end
            end
            // Error responses spend one quiet cycle in RESP before the strobe,
            // so the visible response lands two cycles after acceptance.
            RESP: begin
                if (!wait_q) begin
                    state_d = err_q ? IDLE : GUARD;
                    cnt_d   = '0;
                end
            end
            GUARD: begin
                if (cnt_q == 8'd1) state_d = IDLE;
                else               cnt_d   = cnt_q + 8'd1;
            end
            default: state_d = IDLE;
        endcase

        // Pad and bus outputs are registered from the next-state values.
        act_next   = state_d inside {CMD, ADDR, DUMMY, DATA};
        drive_next = state_d inside {CMD, ADDR};
        gnt_d      = (state_d == IDLE);
        cs_d       = ~act_next;
        ck_d       = act_next & phase_d;
        io_t_d     = drive_next ? 4'b0010 : 4'b1111;
        io_o_d     = drive_next ? {2'b11, 1'b0, sh_d[31]} : 4'b0000;
        rvalid_d   = (state_d == RESP) && !wait_d;
        err_o_d    = rvalid_d && err_d;
        rdata_d    = (rvalid_d && !err_d) ? {rx_d[7:0], rx_d[15:8], rx_d[23:16], rx_d[31:24]} : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            phase_q  <= 1'b0;
            cnt_q    <= '0;
            sh_q     <= '0;
            rx_q     <= '0;
            err_q    <= 1'b0;
            wait_q   <= 1'b0;
            gnt_q    <= 1'b0;
            cs_q     <= 1'b1;
            ck_q     <= 1'b0;
            io_t_q   <= '1;
            io_o_q   <= '0;
            rvalid_q <= 1'b0;
            err_o_q  <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            cnt_q    <= cnt_d;
            sh_q     <= sh_d;
            rx_q     <= rx_d;
            err_q    <= err_d;
            wait_q   <= wait_d;
            gnt_q    <= gnt_d;
            cs_q     <= cs_d;
            ck_q     <= ck_d;
            io_t_q   <= io_t_d;
            io_o_q   <= io_o_d;
            rvalid_q <= rvalid_d;
            err_o_q  <= err_o_d;
            rdata_q  <= rdata_d;
        end
    end

    assign bus.mem_gnt_o    = gnt_q;
    assign bus.mem_rvalid_o = rvalid_q;
    assign bus.mem_err_o    = err_o_q;
    assign bus.mem_rdata_o  = rdata_q;
    assign bus.qspi_cs_o    = cs_q;
    assign bus.qspi_ck_o    = ck_q;
    assign bus.qspi_io_t    = io_t_q;
    assign bus.qspi_io_o    = io_o_q;

endmodule

// File: tb/tb_mem_qspi_read_ctrl.sv
// Randomized bench for mem_qspi_read_ctrl: a behavioural flash and a
// transaction-level timing/data model check every request.
module tb_mem_qspi_read_ctrl;
    localparam int unsigned DUMMY    = 8;
    localparam int unsigned LAST_LOW = 2 * (8 + 24 + DUMMY + 8);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_qspi_read_ctrl_if bus_if ();

    mem_qspi_read_ctrl #(
        .BASE_ADDR   (32'h8000_0000),
        .READ_CMD    (8'h6B),
        .DUMMY_CYCLES(DUMMY)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus_if)
    );

    int unsigned errors = 0;
    int unsigned checks = 0;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    // Flash contents: 11,22,33,44 at 0x000100, a scrambled pattern elsewhere.
    function automatic logic [7:0] flash_byte(input logic [23:0] a);
        if (a >= 24'h000100 && a <= 24'h000103)
            return 8'h11 * 8'(a - 24'h0000FF);
        return a[7:0] ^ (a[15:8] + 8'h5A) ^ {a[3:0], a[23:20]};
    endfunction

    function automatic logic [31:0] exp_word(input logic [31:0] addr);
        logic [23:0] a;
        a = {addr[23:2], 2'b00};
        return {flash_byte(a + 24'd3), flash_byte(a + 24'd2), flash_byte(a + 24'd1), flash_byte(a)};
    endfunction

    int unsigned  cyc = 0;
    int unsigned  sck_n = 0;
    int unsigned  sck_total = 0;
    logic [31:0]  sent = '0;
    int unsigned  last_low_cyc = 0;
    int unsigned  first_low_cyc = 0;

    always @(posedge clk) cyc++;

    always @(negedge bus_if.qspi_cs_o) begin
        sck_n = 0;
        sent  = '0;
    end

    always @(posedge bus_if.qspi_ck_o) begin : flash_model
        int unsigned idx;
        logic [7:0]  b;
        sck_total++;
        if (bus_if.qspi_cs_o === 1'b0) begin
            if (sck_n < 32) begin
                sent = {sent[30:0], bus_if.qspi_io_o[0]};
            end else if (sck_n >= 32 + DUMMY && sck_n < 32 + DUMMY + 8) begin
                idx = sck_n - 32 - DUMMY;
                b   = flash_byte(sent[23:0] + 24'(idx / 2));
                bus_if.qspi_io_i = (idx % 2 == 0) ? b[7:4] : b[3:0];
            end
            sck_n++;
        end
    end

    task automatic issue(input logic we, input logic [31:0] addr);
        int unsigned n;
        @(negedge clk);
        bus_if.mem_req_i  = 1'b1;
        bus_if.mem_we_i   = we;
        bus_if.mem_addr_i = addr;
        n = 0;
        while (bus_if.mem_gnt_o !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check_eq("grant_wait", {31'd0, bus_if.mem_gnt_o}, 32'd1);
        @(posedge clk);
    endtask

    // Observes one request from the cycle after acceptance up to the next grant.
    task automatic watch(input logic we, input logic [31:0] addr, input logic hold,
                         input logic [31:0] next_addr);
        int unsigned cs_first, cs_last, rv_cyc, rv_cnt, gnt_cyc, bad_io, bad_rdata, sck0;
        logic [31:0] rdata;
        logic        err, is_err;
        cs_first = 0; cs_last = 0; rv_cyc = 0; rv_cnt = 0; gnt_cyc = 0;
        bad_io = 0; bad_rdata = 0; rdata = '0; err = 1'b0;
        sck0   = sck_total;
        is_err = we || (addr[31:24] != 8'h80);
        for (int unsigned k = 1; k <= 150 && gnt_cyc == 0; k++) begin
            @(negedge clk);
            if (bus_if.qspi_cs_o == 1'b0) begin
                if (cs_first == 0) begin
                    cs_first      = k;
                    first_low_cyc = cyc;
                end
                cs_last      = k;
                last_low_cyc = cyc;
                if (k <= 64) bad_io += int'(bus_if.qspi_io_t != 4'b0010 || bus_if.qspi_io_o[3:2] != 2'b11);
                else         bad_io += int'(bus_if.qspi_io_t != 4'b1111);
            end
            if (bus_if.mem_rvalid_o) begin
                rv_cnt++;
                rv_cyc = k;
                rdata  = bus_if.mem_rdata_o;
                err    = bus_if.mem_err_o;
            end else if (bus_if.mem_rdata_o != '0) begin
                bad_rdata++;
            end
            if (bus_if.mem_gnt_o) gnt_cyc = k;
            if (k == 1) begin
                if (hold) bus_if.mem_addr_i = next_addr;
                else      bus_if.mem_req_i  = 1'b0;
            end
        end
        check_eq("rvalid_count", rv_cnt, 1);
        check_eq("rdata_idle_zero", bad_rdata, 0);
        check_eq("io_dir", bad_io, 0);
        if (is_err) begin
            check_eq("err_rvalid_cycle", rv_cyc, 2);
            check_eq("err_flag", {31'd0, err}, 1);
            check_eq("err_rdata", rdata, 0);
            check_eq("err_cs_low", cs_first, 0);
            check_eq("err_sck", sck_total - sck0, 0);
            check_eq("err_next_gnt", gnt_cyc, 3);
        end else begin
            check_eq("cs_first_low", cs_first, 1);
            check_eq("cs_last_low", cs_last, LAST_LOW);
            check_eq("rvalid_cycle", rv_cyc, LAST_LOW + 1);
            check_eq("rd_err_flag", {31'd0, err}, 0);
            check_eq("rdata", rdata, exp_word(addr));
            check_eq("cmd_addr_stream", sent, {8'h6B, addr[23:2], 2'b00});
            check_eq("sck_periods", sck_total - sck0, 8 + 24 + DUMMY + 8);
            check_eq("next_gnt", gnt_cyc, LAST_LOW + 4);
        end
    endtask

    initial begin
        int unsigned prev_last, rv_seen;
        logic        rwe;
        logic [31:0] raddr;

        bus_if.mem_req_i  = 1'b0;
        bus_if.mem_we_i   = 1'b0;
        bus_if.mem_addr_i = '0;
        bus_if.qspi_io_i  = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_cs", {31'd0, bus_if.qspi_cs_o}, 1);
        check_eq("rst_ck", {31'd0, bus_if.qspi_ck_o}, 0);
        check_eq("rst_io_t", {28'd0, bus_if.qspi_io_t}, 32'hF);
        check_eq("rst_io_o", {28'd0, bus_if.qspi_io_o}, 0);
        check_eq("rst_rvalid", {31'd0, bus_if.mem_rvalid_o}, 0);
        check_eq("rst_err", {31'd0, bus_if.mem_err_o}, 0);
        check_eq("rst_rdata", bus_if.mem_rdata_o, 0);
        check_eq("rst_gnt", {31'd0, bus_if.mem_gnt_o}, 0);
        rst = 1'b0;
        @(negedge clk);
        check_eq("gnt_after_rst", {31'd0, bus_if.mem_gnt_o}, 1);

        issue(1'b0, 32'h8000_0100); watch(1'b0, 32'h8000_0100, 1'b0, '0);
        issue(1'b0, 32'h8000_0103); watch(1'b0, 32'h8000_0103, 1'b0, '0);
        issue(1'b1, 32'h8000_0000); watch(1'b1, 32'h8000_0000, 1'b0, '0);
        issue(1'b0, 32'h0000_2000); watch(1'b0, 32'h0000_2000, 1'b0, '0);

        // Second request held high across a transfer.
        issue(1'b0, 32'h8000_0100); watch(1'b0, 32'h8000_0100, 1'b1, 32'h8012_3458);
        prev_last = last_low_cyc;
        issue(1'b0, 32'h8012_3458); watch(1'b0, 32'h8012_3458, 1'b0, '0);
        check_eq("cs_gap_ge3", {31'd0, (first_low_cyc - prev_last - 1) >= 3}, 1);

        // Reset in the middle of a read.
        issue(1'b0, 32'h8000_0200);
        for (int unsigned k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) bus_if.mem_req_i = 1'b0;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_eq("abort_cs_high", {31'd0, bus_if.qspi_cs_o}, 1);
        check_eq("abort_rvalid", {31'd0, bus_if.mem_rvalid_o}, 0);
        @(negedge clk);
        rst = 1'b0;
        rv_seen = 0;
        for (int unsigned k = 0; k < 120; k++) begin
            @(negedge clk);
            if (bus_if.mem_rvalid_o) rv_seen++;
        end
        check_eq("abort_no_rvalid", rv_seen, 0);
        issue(1'b0, 32'h8000_0100); watch(1'b0, 32'h8000_0100, 1'b0, '0);

        for (int unsigned i = 0; i < 10; i++) begin
            rwe   = ($urandom_range(0, 4) == 0);
            raddr = $urandom;
            if ($urandom_range(0, 3) != 0) raddr[31:24] = 8'h80;
            issue(rwe, raddr);
            watch(rwe, raddr, 1'b0, '0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1);
    end
endmodule
